// File: rtl/div_64_arbiter_if.sv
// div_64_arbiter_if: requester and shared-divider signals of the 3-way divider arbiter
interface div_64_arbiter_if;
  logic [2:0] req;
  logic [2:0] gnt;
  logic [2:0] done;
  logic [63:0] a0, a1, a2;
  logic [63:0] b0, b1, b2;
  logic [63:0] result;
  logic err;
  logic arb_busy;
  logic div_init;
  logic [63:0] div_a, div_b;
  logic div_busy;
  logic [63:0] div_result;
  modport slave (
    input req, a0, a1, a2, b0, b1, b2, div_busy, div_result,
    output gnt, done, result, err, arb_busy, div_init, div_a, div_b
  );
  modport master (
    output req, a0, a1, a2, b0, b1, b2, div_busy, div_result,
    input gnt, done, result, err, arb_busy, div_init, div_a, div_b
  );
endinterface

// File: rtl/div_64_arbiter.sv
// div_64_arbiter: round-robin arbiter sharing one 64-bit divider among three requesters
module div_64_arbiter #(
  parameter int START_TIMEOUT = 8,
  parameter logic [63:0] ERR_RESULT = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input logic clk,
  input logic rst,
  div_64_arbiter_if.slave bus
);
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] ISSUE = 3'd1;
  localparam logic [2:0] WAIT_START = 3'd2;
  localparam logic [2:0] WAIT_DONE = 3'd3;
  localparam logic [2:0] DONE = 3'd4;
  localparam int CW = $clog2(START_TIMEOUT + 1);
  logic [2:0] state;
  logic [1:0] last, n1, n2, pick;
  logic [CW-1:0] cnt;
  logic [63:0] a_sel, b_sel;
  always_comb begin
    n1 = (last == 2'd2) ? 2'd0 : last + 2'd1;
    n2 = (n1 == 2'd2) ? 2'd0 : n1 + 2'd1;
    pick = bus.req[n1] ? n1 : bus.req[n2] ? n2 : last;
    a_sel = (pick == 2'd0) ? bus.a0 : (pick == 2'd1) ? bus.a1 : bus.a2;
    b_sel = (pick == 2'd0) ? bus.b0 : (pick == 2'd1) ? bus.b1 : bus.b2;
  end
  assign bus.arb_busy = state != IDLE;
  assign bus.div_init = state == ISSUE;
  assign bus.done = (state == DONE) ? bus.gnt : 3'b0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      last <= 2'd2;
      cnt <= '0;
      bus.gnt <= 3'b0;
      bus.err <= 1'b0;
      bus.result <= '0;
      bus.div_a <= '0;
      bus.div_b <= '0;
    end else begin
      case (state)
        IDLE: if (|bus.req) begin
          bus.div_a <= a_sel;
          bus.div_b <= b_sel;
          bus.gnt <= 3'b001 << pick;
          last <= pick;
          if (b_sel == '0) begin
            bus.err <= 1'b1;
            bus.result <= ERR_RESULT;
            state <= DONE;
          end else begin
            state <= ISSUE;
          end
        end
        ISSUE: begin
          cnt <= '0;
          state <= WAIT_START;
        end
        WAIT_START: if (bus.div_busy) begin
          state <= WAIT_DONE;
        end else begin
          cnt <= cnt + CW'(1);
          if (cnt == CW'(START_TIMEOUT - 1)) begin
            bus.err <= 1'b1;
            bus.result <= ERR_RESULT;
            state <= DONE;
          end
        end
        WAIT_DONE: if (!bus.div_busy) begin
          bus.err <= 1'b0;
          bus.result <= bus.div_result;
          state <= DONE;
        end
        DONE: begin
          bus.gnt <= 3'b0;
          bus.err <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_64_arbiter.sv
// tb_div_64_arbiter: randomized directed checks of div_64_arbiter against a transaction-level model
module tb_div_64_arbiter;
  localparam int TO = 8;
  localparam logic [63:0] ERR = 64'hFFFF_FFFF_FFFF_FFFF;
  logic clk = 1'b0;
  logic rst = 1'b1;
  div_64_arbiter_if bus();
  div_64_arbiter #(.START_TIMEOUT(TO), .ERR_RESULT(ERR)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int checks = 0;
  int failures = 0;
  int busy_len = 4;
  bit never_busy = 1'b0;
  int bcnt = 0;
  int inits = 0;
  int dones = 0;
  int exp_last = 2;
  logic [63:0] q = '0;
  logic [63:0] av [3];
  logic [63:0] bv [3];
  assign bus.div_result = q;
  always @(posedge clk) begin
    if (rst) begin
      bus.div_busy <= 1'b0;
      bcnt <= 0;
    end else if (bus.div_init) begin
      inits <= inits + 1;
      q <= (bus.div_b == '0) ? '0 : bus.div_a / bus.div_b;
      bus.div_busy <= !never_busy;
      bcnt <= busy_len;
    end else if (bcnt > 1) begin
      bcnt <= bcnt - 1;
    end else begin
      bcnt <= 0;
      bus.div_busy <= 1'b0;
    end
    if (|bus.done) dones <= dones + 1;
  end
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic int rr(input int lst, input logic [2:0] r);
    for (int k = 1; k <= 3; k++) if (r[(lst + k) % 3]) return (lst + k) % 3;
    return -1;
  endfunction
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (bus.done === 3'b0 && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    if (bus.done === 3'b0) begin
      checks++;
      failures++;
      $error("FAIL done_timeout observed=no_done expected=done_within_300");
    end
  endtask
  task automatic txn(input logic [2:0] r, input bit drop, input string tag, output int cyc);
    int w;
    bit ee;
    logic [63:0] er;
    bus.a0 = av[0]; bus.a1 = av[1]; bus.a2 = av[2];
    bus.b0 = bv[0]; bus.b1 = bv[1]; bus.b2 = bv[2];
    bus.req = r;
    w = rr(exp_last, r);
    exp_last = w;
    ee = (bv[w] == '0) || never_busy;
    er = ee ? ERR : av[w] / bv[w];
    wait_done(cyc);
    check({tag, "_done"}, 64'(bus.done), 64'(3'b001 << w));
    check({tag, "_gnt"}, 64'(bus.gnt), 64'(3'b001 << w));
    check({tag, "_result"}, bus.result, er);
    check({tag, "_err"}, 64'(bus.err), 64'(ee));
    check({tag, "_div_a"}, bus.div_a, av[w]);
    check({tag, "_div_b"}, bus.div_b, bv[w]);
    if (drop) bus.req = 3'b0;
    @(negedge clk);
    check({tag, "_idle"}, 64'({bus.gnt, bus.done, bus.arb_busy}), 64'(0));
  endtask
  initial begin
    int cyc;
    int i0;
    int d0;
    logic [2:0] r;
    bus.req = 3'b0;
    for (int k = 0; k < 3; k++) begin
      av[k] = '0;
      bv[k] = 64'd1;
    end
    bus.a0 = '0; bus.a1 = '0; bus.a2 = '0;
    bus.b0 = '0; bus.b1 = '0; bus.b2 = '0;
    repeat (3) @(negedge clk);
    check("rst_ctl", 64'({bus.gnt, bus.done, bus.err, bus.div_init, bus.arb_busy}), 64'(0));
    check("rst_result", bus.result, 64'd0);
    check("rst_div_a", bus.div_a, 64'd0);
    check("rst_div_b", bus.div_b, 64'd0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      av[k] = 64'd1000;
      bv[k] = 64'd10;
    end
    busy_len = 2;
    for (int i = 0; i < 4; i++) txn(3'b111, i == 3, "rr", cyc);
    av[0] = 64'd100;
    bv[0] = 64'd7;
    busy_len = 64;
    i0 = inits;
    txn(3'b001, 1'b1, "single", cyc);
    check("single_q14", bus.result, 64'd14);
    check("single_inits", 64'(inits - i0), 64'd1);
    av[1] = {$urandom, $urandom};
    bv[1] = '0;
    i0 = inits;
    txn(3'b010, 1'b1, "dz", cyc);
    check("dz_inits", 64'(inits - i0), 64'd0);
    check("dz_latency_le2", 64'(cyc <= 2), 64'd1);
    never_busy = 1'b1;
    av[2] = {$urandom, $urandom};
    bv[2] = {$urandom, $urandom} | 64'd1;
    txn(3'b100, 1'b1, "timeout", cyc);
    check("timeout_latency", 64'(cyc), 64'(2 + TO));
    never_busy = 1'b0;
    busy_len = 3;
    txn(3'b100, 1'b1, "after_to", cyc);
    for (int i = 0; i < 12; i++) begin
      for (int k = 0; k < 3; k++) begin
        av[k] = {$urandom, $urandom};
        bv[k] = ($urandom_range(0, 3) == 0) ? 64'd0 :
                ($urandom_range(0, 1) == 1) ? 64'($urandom_range(1, 1000)) : {$urandom, $urandom};
      end
      r = 3'($urandom_range(1, 7));
      busy_len = $urandom_range(1, 6);
      txn(r, 1'b1, "rand", cyc);
    end
    av[0] = 64'd5000;
    bv[0] = 64'd3;
    busy_len = 20;
    bus.a0 = av[0];
    bus.b0 = bv[0];
    bus.req = 3'b001;
    exp_last = rr(exp_last, 3'b001);
    repeat (8) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_ctl", 64'({bus.gnt, bus.done, bus.err, bus.div_init, bus.arb_busy}), 64'(0));
    check("midrst_result", bus.result, 64'd0);
    check("midrst_div_ab", 64'(|{bus.div_a, bus.div_b}), 64'd0);
    bus.req = 3'b0;
    d0 = dones;
    repeat (25) @(negedge clk);
    check("midrst_no_done", 64'(dones - d0), 64'd0);
    rst = 1'b0;
    exp_last = 2;
    av[0] = 64'd81; bv[0] = 64'd9;
    av[1] = 64'd64; bv[1] = 64'd8;
    busy_len = 3;
    txn(3'b011, 1'b1, "post_rst", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/div_64_arbiter.md
DIV_64_ARBITER -- requirements
Module: div_64_arbiter

Interface
REQ-001 Parameter: START_TIMEOUT, default 8, maximum cycles to wait for div_busy to rise after div_init.
REQ-002 Parameter: ERR_RESULT, default 64'hFFFF_FFFF_FFFF_FFFF, value returned on a divide-by-zero or timeout error.
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous and active-high.
REQ-005 Port: req  input  3  per-requester level request; requester n holds req[n] high until done[n].
REQ-006 Port: a0, a1, a2  input  64 each  dividend of requester n; stable while req[n] is high.
REQ-007 Port: b0, b1, b2  input  64 each  divisor of requester n; stable while req[n] is high.
REQ-008 Port: gnt  output  3  one-hot grant; held from acceptance to the end of the DONE cycle.
REQ-009 Port: done  output  3  one-cycle completion pulse to the granted requester.
REQ-010 Port: result  output  64  quotient; valid only while any done bit is high.
REQ-011 Port: err  output  1  high with done when the result is ERR_RESULT because of an error.
REQ-012 Port: arb_busy  output  1  high in every state except IDLE.
REQ-013 Port: div_init  output  1  start pulse to the shared 64-bit divider.
REQ-014 Port: div_a, div_b  output  64 each  registered operands driven to the divider.
REQ-015 Port: div_busy  input  1  divider busy flag.
REQ-016 Port: div_result  input  64  divider quotient.

Function
REQ-017 The FSM SHALL have the states IDLE, ISSUE, WAIT_START, WAIT_DONE and DONE, with one transaction in flight at a time.
REQ-018 In IDLE with any req bit high, the arbiter SHALL pick one requester by round-robin, starting at (last_granted+1) mod 3.
- last_granted resets to 2, so requester 0 wins first.
REQ-019 On acceptance, the arbiter SHALL:
- register a_n into div_a and b_n into div_b;
- set gnt[n] and update last_granted;
- go to ISSUE, or go directly to DONE with err=1 if b_n==0 (the divider is not started).
REQ-020 ISSUE SHALL assert div_init for exactly one cycle, clear the timeout counter, then go to WAIT_START.
REQ-021 WAIT_START, each cycle:
- div_busy=1 -> WAIT_DONE;
- otherwise increment the counter; on reaching START_TIMEOUT -> DONE with err=1.
REQ-022 WAIT_DONE SHALL wait with no timeout; on the first cycle div_busy=0 it SHALL register div_result into result and go to DONE with err=0.
REQ-023 DONE SHALL last one cycle and then go to IDLE, with:
- done[n]=1 and gnt[n]=1;
- result and err valid.
REQ-024 After the DONE cycle, gnt SHALL clear and result SHALL hold its value (it is don't-care to consumers).
REQ-025 A req bit still high in the IDLE cycle after DONE SHALL be treated as a new request.
REQ-026 Requests that arrive or drop while arb_busy=1 SHALL NOT affect the current transaction.
REQ-027 If req[n] is dropped mid-transaction, the arbiter SHALL still complete the transaction and pulse done[n].
REQ-028 Error results SHALL be ERR_RESULT, with div_result ignored.
REQ-029 div_a and div_b SHALL stay constant from acceptance until leaving DONE.
REQ-030 Minimum latency from req to done SHALL be 2 cycles for divide-by-zero and 4 cycles plus the divider busy time otherwise.

Reset
REQ-031 While rst=1, asynchronously:
- state=IDLE;
- gnt, done, err, div_init and arb_busy = 0;
- result, div_a and div_b = 0;
- counter=0 and last_granted=2.
REQ-032 Reset mid-transaction SHALL abandon the transaction with no done pulse; the requester re-arbitrates after reset.
REQ-033 The first acceptance SHALL occur no earlier than the first rising clk edge after rst falls.

Verification
REQ-034 Single request: req=3'b001, a0=100, b0=7, divider model busy for 64 cycles -> one div_init pulse, done=3'b001, result=14, err=0.
REQ-035 Simultaneous requests: req=3'b111 held, each with a=1000, b=10 -> grants in the order 0, 1, 2, 0; each done carries result=100; no requester is granted twice before the others are served.
REQ-036 Divide-by-zero: req[1]=1, b1=0 -> no div_init, done=3'b010 two cycles after req, result=ERR_RESULT, err=1.
REQ-037 Timeout: divider model never raises busy -> done after START_TIMEOUT cycles in WAIT_START, err=1, result=ERR_RESULT; the next request proceeds normally.
REQ-038 Reset mid-operation: rst pulsed during WAIT_DONE -> all outputs 0 immediately and no done pulse; a new request after reset completes normally with last_granted reset (requester 0 wins a tie).
